// File: rtl/matrix_proc_pkg.sv
// Shared types for the matrix job arbiter: controller state encoding and
// the round-robin index stepping helper.
package matrix_proc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } arbState_t;

    function automatic int unsigned rrNext(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward (wrapping)
// and returns the first active request as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grantIdx
);
    import matrix_proc_pkg::*;

    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] cand;
        logic found;
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = rrNext(32'(ptr), NUM_REQ);
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grantIdx    = cand;
            end
            idx = rrNext(idx, NUM_REQ);
        end
    end

endmodule

// File: rtl/matrix_job_arbiter.sv
// Round-robin job dispatcher feeding a single matrix processor and returning
// completion records. Optional RUN watchdog enabled by MATRIX_ARB_WATCHDOG_EN.
module matrix_job_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 12,
    parameter int TMO_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*CNT_W-1:0]   req_count,
    output logic                       mp_start,
    output logic [ADDR_W-1:0]          mp_addr,
    output logic [CNT_W-1:0]           mp_count,
    input  logic                       mp_done,
    output logic                       done_valid,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       done_err,
    input  logic                       done_ready
);
    import matrix_proc_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    arbState_t        state;
    arbState_t        nextState;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idReg;
    logic [ADDR_W-1:0] addrReg;
    logic [CNT_W-1:0] cntReg;
    logic [NUM_REQ-1:0] grantVec;
    logic [IDX_W-1:0] grantIdx;
    logic             anyReq;
    logic             takeGrant;

    assign anyReq    = |req_valid;
    assign takeGrant = (state == IDLE) && anyReq;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uArb (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grantVec),
        .grantIdx (grantIdx)
    );

`ifdef MATRIX_ARB_WATCHDOG_EN
    logic [TMO_W-1:0] wdCnt;
    logic             errReg;
    logic             wdExpire;

    // Fires on the RUN cycle whose increment would land on all-ones.
    assign wdExpire = &(wdCnt ^ TMO_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdCnt  <= '0;
            errReg <= 1'b0;
        end else if (state == START) begin
            wdCnt  <= '0;
            errReg <= 1'b0;
        end else if (state == RUN) begin
            wdCnt  <= wdCnt + TMO_W'(1);
            errReg <= !mp_done && wdExpire;
        end
    end

    assign done_err = errReg;
`else
    assign done_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:   if (anyReq) nextState = START;
            START:  nextState = (cntReg != '0) ? RUN : REPORT;
            RUN: begin
                if (mp_done) nextState = REPORT;
`ifdef MATRIX_ARB_WATCHDOG_EN
                else if (wdExpire) nextState = REPORT;
`endif
            end
            REPORT: if (done_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted even though state reads IDLE.
    always_comb begin
        req_ready  = '0;
        mp_start   = 1'b0;
        done_valid = 1'b0;
        case (state)
            IDLE:    if (rst_n) req_ready = grantVec;
            START:   mp_start = (cntReg != '0);
            REPORT:  done_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= IDX_W'(NUM_REQ - 1);
            idReg   <= '0;
            addrReg <= '0;
            cntReg  <= '0;
        end else if (takeGrant) begin
            ptr     <= grantIdx;
            idReg   <= grantIdx;
            addrReg <= req_addr[32'(grantIdx) * ADDR_W +: ADDR_W];
            cntReg  <= req_count[32'(grantIdx) * CNT_W +: CNT_W];
        end
    end

    assign mp_addr  = addrReg;
    assign mp_count = cntReg;
    assign done_id  = idReg;

endmodule
